// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix encodings and burst-length helper.
package ahb_mtx_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Beats still owed after the NONSEQ of a burst; undefined-length INCR owes none.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        logic [3:0] beats;
        beats = 4'd0;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_priority_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last_grant,
    output logic [PORT_W-1:0]    winner,
    output logic                 any_req
);

    int   idx;
    logic found;

    always_comb begin
        winner  = last_grant;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        // Offset NUM_PORTS lands back on last_grant, so a lone requester re-wins.
        for (int off = 1; off <= NUM_PORTS; off++) begin
            idx = (int'(last_grant) + off) % NUM_PORTS;
            if (!found && req[idx[PORT_W-1:0]]) begin
                winner = idx[PORT_W-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_rr_output_arbiter.sv
// Round-robin output-stage arbiter for one AHB bus-matrix slave port.
// Define ARB_BURST_HOLD_EN to freeze the grant for the length of fixed-length bursts.
module ahb_rr_output_arbiter
    import ahb_mtx_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold
);

    logic [PORT_W-1:0] last_grant;
    logic [PORT_W-1:0] grant_d;
    logic [PORT_W-1:0] last_grant_d;
    logic              no_port_d;
    logic [PORT_W-1:0] winner;
    logic              any_req;
    logic              hold_d;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .req        (req_port),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

`ifdef ARB_BURST_HOLD_EN
    logic [3:0] beat_cnt;
    logic [3:0] beat_cnt_d;
    logic       hold_q;

    // Beats remaining after the transfer accepted on this edge.
    always_comb begin
        beat_cnt_d = beat_cnt;
        if (!HSELM || HTRANSM == HTRANS_IDLE) begin
            beat_cnt_d = 4'd0;
        end else if (HTRANSM == HTRANS_NONSEQ) begin
            beat_cnt_d = burst_beats(HBURSTM);
        end else if (HTRANSM == HTRANS_SEQ && beat_cnt != 4'd0) begin
            beat_cnt_d = beat_cnt - 4'd1;
        end
    end

    assign hold_d = (beat_cnt_d != 4'd0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beat_cnt <= 4'd0;
            hold_q   <= 1'b0;
        end else if (HREADYM) begin
            beat_cnt <= beat_cnt_d;
            hold_q   <= hold_d;
        end
    end

    assign burst_hold = hold_q;
`else
    logic unused_burst;

    assign hold_d       = 1'b0;
    assign burst_hold   = 1'b0;
    assign unused_burst = ^HBURSTM;
`endif

    always_comb begin
        grant_d      = addr_in_port;
        last_grant_d = last_grant;
        no_port_d    = 1'b1;
        if (HMASTLOCKM) begin
            no_port_d = 1'b0;
        end else if (hold_d) begin
            no_port_d = 1'b0;
        end else if (any_req) begin
            grant_d      = winner;
            last_grant_d = winner;
            no_port_d    = 1'b0;
        end else if (HSELM && HTRANSM != HTRANS_IDLE) begin
            no_port_d = 1'b0;
        end else if (HSELM) begin
            // Selected but idle: keep the port parked so the slave sees a stable owner.
            no_port_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
            last_grant   <= PORT_W'(NUM_PORTS - 1);
        end else if (HREADYM) begin
            addr_in_port <= grant_d;
            no_port      <= no_port_d;
            last_grant   <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_ahb_rr_output_arbiter.sv
// Randomised + directed bench for ahb_rr_output_arbiter with a queue-based scoreboard.
module tb_ahb_rr_output_arbiter;

    localparam int NP = 4;
    localparam int PW = 2;
    localparam int W  = PW + 2;

    logic          HCLK;
    logic          HRESETn;
    logic [NP-1:0] req_port;
    logic          HREADYM;
    logic          HSELM;
    logic [1:0]    HTRANSM;
    logic [2:0]    HBURSTM;
    logic          HMASTLOCKM;
    logic [PW-1:0] addr_in_port;
    logic          no_port;
    logic          burst_hold;

    ahb_rr_output_arbiter #(.NUM_PORTS(NP)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .burst_hold   (burst_hold)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: grant owner, idle flag, last winner, beats still owed.
    int m_grant, m_last, m_rem;
    bit m_none, m_hold;

    function automatic int burst_len(input logic [2:0] b);
        if (b[2:1] == 2'b00) return 1;
        return 1 << (int'(b[2:1]) + 1);
    endfunction

    task automatic model_reset();
        m_grant = 0; m_none = 1; m_last = NP - 1; m_rem = 0; m_hold = 0;
    endtask

    task automatic model_edge(input logic [NP-1:0] req, input logic ready, input logic sel,
                              input logic [1:0] trans, input logic [2:0] burst, input logic lock);
        int rem_next;
        bit hold;
        if (!ready) return;
        rem_next = 0;
`ifdef ARB_BURST_HOLD_EN
        if (!sel || trans == 2'b00) rem_next = 0;
        else if (trans == 2'b10) rem_next = burst_len(burst) - 1;
        else if (trans == 2'b11) rem_next = (m_rem > 0) ? m_rem - 1 : 0;
        else rem_next = m_rem;
`endif
        hold = (rem_next > 0);
        if (lock || hold) begin
            m_none = 0;
        end else if (req != 0) begin
            for (int k = 1; k <= NP; k++) begin
                if (req[(m_last + k) % NP]) begin
                    m_grant = (m_last + k) % NP;
                    break;
                end
            end
            m_last = m_grant;
            m_none = 0;
        end else begin
            m_none = !sel;
        end
        m_rem  = rem_next;
        m_hold = hold;
    endtask

    task automatic push_exp();
        logic [PW-1:0] g;
        g = m_grant[PW-1:0];
        exp_q.push_back({m_hold, m_none, g});
    endtask

    // Called at a negedge: drive, predict, then move to the next negedge.
    task automatic drive(input logic [NP-1:0] req, input logic ready, input logic sel,
                         input logic [1:0] trans, input logic [2:0] burst, input logic lock);
        req_port = req; HREADYM = ready; HSELM = sel;
        HTRANSM = trans; HBURSTM = burst; HMASTLOCKM = lock;
        model_edge(req, ready, sel, trans, burst, lock);
        push_exp();
        @(negedge HCLK);
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        req_port = '0; HREADYM = 1'b0; HSELM = 1'b0;
        HTRANSM = 2'b00; HBURSTM = 3'b000; HMASTLOCKM = 1'b0;
        model_reset();
        push_exp();
        @(negedge HCLK);
        HRESETn = 1'b1;
        push_exp();
        @(negedge HCLK);
    endtask

    // Monitor: every edge the DUT presents a new registered decision.
    initial begin
        logic [W-1:0] exp_v, act_v;
        forever begin
            @(posedge HCLK);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {burst_hold, no_port, addr_in_port};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL arb_out t=%0t: got hold=%0b none=%0b port=%0d, expected hold=%0b none=%0b port=%0d",
                             $time, act_v[W-1], act_v[W-2], act_v[PW-1:0],
                             exp_v[W-1], exp_v[W-2], exp_v[PW-1:0]);
                end
            end
        end
    end

    initial begin
        HRESETn = 1'b0;
        req_port = '0; HREADYM = 1'b0; HSELM = 1'b0;
        HTRANSM = 2'b00; HBURSTM = 3'b000; HMASTLOCKM = 1'b0;
        model_reset();
        @(negedge HCLK);
        do_reset();

        // Every port requesting, SINGLE transfers: strict rotation.
        for (int i = 0; i < 5; i++) drive(4'b1111, 1, 1, 2'b10, 3'b000, 0);

        // Port 1 takes ownership, then INCR4 with ports 0 and 2 waiting.
        drive(4'b0010, 1, 0, 2'b00, 3'b000, 0);
        drive(4'b0101, 1, 1, 2'b10, 3'b011, 0);
        for (int i = 0; i < 3; i++) drive(4'b0101, 1, 1, 2'b11, 3'b011, 0);
        drive(4'b0000, 1, 0, 2'b00, 3'b000, 0);

        // INCR4 again, interrupted by BUSY beats and wait states.
        drive(4'b0010, 1, 0, 2'b00, 3'b000, 0);
        drive(4'b0101, 1, 1, 2'b10, 3'b011, 0);
        drive(4'b0101, 1, 1, 2'b01, 3'b011, 0);
        drive(4'b0101, 1, 1, 2'b11, 3'b011, 0);
        drive(4'b0101, 1, 1, 2'b01, 3'b011, 0);
        for (int i = 0; i < 3; i++) drive(4'b0101, 0, 1, 2'b11, 3'b011, 0);
        drive(4'b0101, 1, 1, 2'b11, 3'b011, 0);
        drive(4'b0101, 1, 1, 2'b11, 3'b011, 0);
        drive(4'b0000, 1, 0, 2'b00, 3'b000, 0);

        // Port 3 holds a locked sequence against a waiting port 0.
        drive(4'b1000, 1, 0, 2'b00, 3'b000, 0);
        for (int i = 0; i < 6; i++) drive(4'b0001, 1, 1, 2'b10, 3'b000, 1);
        drive(4'b0001, 1, 1, 2'b10, 3'b000, 0);

        // Nobody requesting and slave deselected, then reset mid-INCR8.
        for (int i = 0; i < 3; i++) drive(4'b0000, 1, 0, 2'b00, 3'b000, 0);
        drive(4'b0100, 1, 0, 2'b00, 3'b000, 0);
        drive(4'b0011, 1, 1, 2'b10, 3'b101, 0);
        drive(4'b0011, 1, 1, 2'b11, 3'b101, 0);
        drive(4'b0011, 1, 1, 2'b11, 3'b101, 0);
        do_reset();
        drive(4'b0000, 1, 1, 2'b11, 3'b101, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic sel_r;
            sel_r = ($urandom_range(0, 3) != 0);
            drive(NP'($urandom_range(0, 15)) & {NP{($urandom_range(0, 2) != 0)}},
                  ($urandom_range(0, 4) != 0), sel_r,
                  sel_r ? 2'($urandom_range(0, 3)) : 2'b00,
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(negedge HCLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
